// File: rtl/formula_2_distributor_pkg.sv
// Shared constants and helpers for the formula_2 distributor/collector.
//   FORMULA_W   : result/argument width
//   MAX_WORKERS : largest supported worker bank
//   ptr_inc     : modulo-n increment for slot pointers (n need not be 2^k)
package formula_2_distributor_pkg;
  localparam int FORMULA_W   = 32;
  localparam int MAX_WORKERS = 16;
  localparam int MAX_PTR_W   = $clog2(MAX_WORKERS);

  function automatic logic [MAX_PTR_W-1:0] ptr_inc(input logic [MAX_PTR_W-1:0] ptr,
                                                    input int n);
    return (ptr == MAX_PTR_W'(n - 1)) ? '0 : ptr + MAX_PTR_W'(1);
  endfunction
endpackage

// File: rtl/formula_2_dist_slot.sv
// One reorder slot: tracks dispatch (busy), completion (done) and holds the
// worker result until the in-order emitter drains it.
//   set_busy      : slot dispatched this cycle
//   res_vld/res   : worker result strobe and data
//   emit          : slot drained to the output this cycle
//   busy/done     : slot state
//   buf_data      : captured result
//   err_pulse     : result strobe arrived while idle or already holding a result
module formula_2_dist_slot
  import formula_2_distributor_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_busy,
  input  logic                 res_vld,
  input  logic [FORMULA_W-1:0] res,
  input  logic                 emit,
  output logic                 busy,
  output logic                 done,
  output logic [FORMULA_W-1:0] buf_data,
  output logic                 err_pulse
);
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [FORMULA_W-1:0] buf_q, buf_d;
  logic                 capture;

  assign capture   = res_vld && busy_q && !done_q;
  assign err_pulse = res_vld && !capture;

  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    buf_d  = buf_q;
    if (capture) begin
      buf_d  = res;
      done_d = 1'b1;
    end
    // emit needs done=1, so it never coincides with a capture into this slot
    if (emit) begin
      busy_d = 1'b0;
      done_d = 1'b0;
    end
    // dispatch needs busy=0, so it never coincides with emit of this slot
    if (set_busy) busy_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      buf_q  <= buf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign buf_data = buf_q;
endmodule

// File: rtl/formula_2_distributor.sv
// In-order dispatcher/collector for a bank of N_WORKERS formula_2 workers.
// Triples are handed out round-robin; results return in any order and are
// re-emitted in submission order through a one-cycle strobe.
//   clk, rst (async, active low)
//   arg_vld/arg_rdy, a/b/c        : argument input handshake
//   res_vld/res                   : in-order result strobe (no backpressure)
//   wrk_arg_vld, wrk_a/b/c        : one-hot start pulse + broadcast args
//   wrk_res_vld, wrk_res          : per-worker result strobe + packed results
//   err                           : sticky protocol error
module formula_2_distributor
  import formula_2_distributor_pkg::*;
#(
  parameter int N_WORKERS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           arg_vld,
  input  logic [FORMULA_W-1:0]           a,
  input  logic [FORMULA_W-1:0]           b,
  input  logic [FORMULA_W-1:0]           c,
  output logic                           arg_rdy,
  output logic                           res_vld,
  output logic [FORMULA_W-1:0]           res,
  output logic [N_WORKERS-1:0]           wrk_arg_vld,
  output logic [FORMULA_W-1:0]           wrk_a,
  output logic [FORMULA_W-1:0]           wrk_b,
  output logic [FORMULA_W-1:0]           wrk_c,
  input  logic [N_WORKERS-1:0]           wrk_res_vld,
  input  logic [N_WORKERS*FORMULA_W-1:0] wrk_res,
  output logic                           err
);
  localparam int PW = $clog2(N_WORKERS);

  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                   res_vld_q, res_vld_d;
  logic [FORMULA_W-1:0]   res_q, res_d;
  logic [N_WORKERS-1:0]   wav_q, wav_d;
  logic [FORMULA_W-1:0]   wa_q, wa_d, wb_q, wb_d, wc_q, wc_d;
  logic                   err_q, err_d;

  logic [N_WORKERS-1:0]                busy, done, err_pulse, set_busy, emit_sel;
  logic [N_WORKERS-1:0][FORMULA_W-1:0] buf_arr;
  logic                                accept, emit;

  assign arg_rdy = !busy[wr_ptr_q];
  assign accept  = arg_vld && arg_rdy;
  assign emit    = done[rd_ptr_q];

  for (genvar i = 0; i < N_WORKERS; i++) begin : g_slot
    assign set_busy[i] = accept && (wr_ptr_q == PW'(i));
    assign emit_sel[i] = emit && (rd_ptr_q == PW'(i));
    formula_2_dist_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .set_busy  (set_busy[i]),
      .res_vld   (wrk_res_vld[i]),
      .res       (wrk_res[i*FORMULA_W +: FORMULA_W]),
      .emit      (emit_sel[i]),
      .busy      (busy[i]),
      .done      (done[i]),
      .buf_data  (buf_arr[i]),
      .err_pulse (err_pulse[i])
    );
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    res_vld_d = emit;
    res_d     = res_q;
    wav_d     = '0;
    wa_d      = wa_q;
    wb_d      = wb_q;
    wc_d      = wc_q;
    err_d     = err_q | (|err_pulse);
    if (accept) begin
      wav_d[wr_ptr_q] = 1'b1;
      wa_d            = a;
      wb_d            = b;
      wc_d            = c;
      wr_ptr_d        = PW'(ptr_inc(MAX_PTR_W'(wr_ptr_q), N_WORKERS));
    end
    if (emit) begin
      res_d    = buf_arr[rd_ptr_q];
      rd_ptr_d = PW'(ptr_inc(MAX_PTR_W'(rd_ptr_q), N_WORKERS));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
      wav_q     <= '0;
      wa_q      <= '0;
      wb_q      <= '0;
      wc_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
      wav_q     <= wav_d;
      wa_q      <= wa_d;
      wb_q      <= wb_d;
      wc_q      <= wc_d;
      err_q     <= err_d;
    end
  end

  assign res_vld     = res_vld_q;
  assign res         = res_q;
  assign wrk_arg_vld = wav_q;
  assign wrk_a       = wa_q;
  assign wrk_b       = wb_q;
  assign wrk_c       = wc_q;
  assign err         = err_q;
endmodule

// File: tb/tb_formula_2_distributor.sv
// Directed bench: N=4 instance for reset/ordering/backpressure/error cases,
// N=3 instance with a latency-randomised worker model for wrap and ordering.
module tb_formula_2_distributor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // N=4 instance
  logic        arg_vld = 1'b0;
  logic [31:0] a = '0, b = '0, c = '0;
  logic        arg_rdy, res_vld, err;
  logic [31:0] res, wrk_a, wrk_b, wrk_c;
  logic [3:0]  wrk_arg_vld;
  logic [3:0]  wrk_res_vld = '0;
  logic [127:0] wrk_res = '0;

  formula_2_distributor #(.N_WORKERS(4)) u4 (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .a(a), .b(b), .c(c),
    .arg_rdy(arg_rdy), .res_vld(res_vld), .res(res),
    .wrk_arg_vld(wrk_arg_vld), .wrk_a(wrk_a), .wrk_b(wrk_b), .wrk_c(wrk_c),
    .wrk_res_vld(wrk_res_vld), .wrk_res(wrk_res), .err(err));

  // N=3 instance
  logic        arg_vld3 = 1'b0;
  logic [31:0] a3 = '0, b3 = '0, c3 = '0;
  logic        arg_rdy3, res_vld3, err3;
  logic [31:0] res3, wrk_a3, wrk_b3, wrk_c3;
  logic [2:0]  wrk_arg_vld3;
  logic [2:0]  w3_vld = '0;
  logic [2:0][31:0] w3_res = '0;

  formula_2_distributor #(.N_WORKERS(3)) u3 (
    .clk(clk), .rst(rst), .arg_vld(arg_vld3), .a(a3), .b(b3), .c(c3),
    .arg_rdy(arg_rdy3), .res_vld(res_vld3), .res(res3),
    .wrk_arg_vld(wrk_arg_vld3), .wrk_a(wrk_a3), .wrk_b(wrk_b3), .wrk_c(wrk_c3),
    .wrk_res_vld(w3_vld), .wrk_res(w3_res), .err(err3));

  // Worker model for u3: result = a+b+c after a random 5..40 cycle latency
  int cnt3 [3] = '{0, 0, 0};
  logic [31:0] pend3 [3];
  initial begin
    forever begin
      @(posedge clk); #1;
      w3_vld = '0;
      for (int i = 0; i < 3; i++) begin
        if (cnt3[i] > 0) begin
          cnt3[i]--;
          if (cnt3[i] == 0) begin
            w3_vld[i] = 1'b1;
            w3_res[i] = pend3[i];
          end
        end
        if (wrk_arg_vld3[i]) begin
          cnt3[i]  = int'($urandom_range(5, 40));
          pend3[i] = wrk_a3 + wrk_b3 + wrk_c3;
        end
      end
    end
  end

  logic [31:0] got3 [$];
  initial begin
    forever begin
      @(posedge clk); #1;
      if (res_vld3) got3.push_back(res3);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  logic [31:0] exp3 [$];

  initial begin
    // reset state
    #2;
    chk("rst_arg_rdy", 32'(arg_rdy), 1);
    chk("rst_res_vld", 32'(res_vld), 0);
    chk("rst_res", res, 0);
    chk("rst_wav", 32'(wrk_arg_vld), 0);
    chk("rst_wa", wrk_a, 0);
    chk("rst_err", 32'(err), 0);
    tick(); rst = 1'b1; tick();

    // 1: reset mid-flight
    arg_vld = 1; a = 1; b = 2; c = 3; tick();
    a = 4; b = 5; c = 6; tick();
    arg_vld = 0;
    chk("t1_wav_pre", 32'(wrk_arg_vld), 32'h2);
    rst = 1'b0; tick();
    chk("t1_wav", 32'(wrk_arg_vld), 0);
    chk("t1_wa", wrk_a, 0);
    chk("t1_wc", wrk_c, 0);
    chk("t1_res_vld", 32'(res_vld), 0);
    chk("t1_arg_rdy", 32'(arg_rdy), 1);
    chk("t1_err", 32'(err), 0);
    rst = 1'b1; tick();

    // 2: single transaction, lands on worker 0 after reset
    arg_vld = 1; a = 12; b = 12; c = 16; tick();
    arg_vld = 0;
    chk("t2_wav", 32'(wrk_arg_vld), 32'h1);
    chk("t2_wc", wrk_c, 16);
    chk("t2_wa", wrk_a, 12);
    tick();
    chk("t2_wav_off", 32'(wrk_arg_vld), 0);
    repeat (3) tick();
    wrk_res_vld = 4'b0001; wrk_res[31:0] = 4; tick();
    wrk_res_vld = '0;
    chk("t2_no_early", 32'(res_vld), 0);
    tick();
    chk("t2_res_vld", 32'(res_vld), 1);
    chk("t2_res", res, 4);
    tick();
    chk("t2_res_vld_off", 32'(res_vld), 0);
    chk("t2_res_hold", res, 4);

    // 3: out-of-order completion
    do_reset();
    arg_vld = 1; a = 1; b = 1; c = 1; tick();
    a = 2; tick();
    arg_vld = 0;
    chk("t3_wav_w1", 32'(wrk_arg_vld), 32'h2);
    repeat (2) tick();
    wrk_res_vld = 4'b0010; wrk_res[63:32] = 7; tick();
    wrk_res_vld = '0; tick();
    chk("t3_hold_w1", 32'(res_vld), 0);
    repeat (3) tick();
    chk("t3_still_hold", 32'(res_vld), 0);
    wrk_res_vld = 4'b0001; wrk_res[31:0] = 3; tick();
    wrk_res_vld = '0; tick();
    chk("t3_first_vld", 32'(res_vld), 1);
    chk("t3_first", res, 3);
    tick();
    chk("t3_second_vld", 32'(res_vld), 1);
    chk("t3_second", res, 7);
    tick();
    chk("t3_idle", 32'(res_vld), 0);
    chk("t3_err", 32'(err), 0);

    // 4: backpressure
    do_reset();
    for (int k = 0; k < 4; k++) begin
      arg_vld = 1; a = 32'(10 + k); b = 0; c = 0; tick();
    end
    a = 99; b = 98; c = 97;
    chk("t4_rdy_low", 32'(arg_rdy), 0);
    tick();
    chk("t4_held_wav", 32'(wrk_arg_vld), 0);
    chk("t4_held_wa", wrk_a, 13);
    wrk_res_vld = 4'b0001; wrk_res[31:0] = 9; tick();
    wrk_res_vld = '0;
    chk("t4_rdy_cap", 32'(arg_rdy), 0);
    tick();
    chk("t4_res_vld", 32'(res_vld), 1);
    chk("t4_res", res, 9);
    chk("t4_rdy_rise", 32'(arg_rdy), 1);
    tick();
    arg_vld = 0;
    chk("t4_fifth_wav", 32'(wrk_arg_vld), 32'h1);
    chk("t4_fifth_wa", wrk_a, 99);
    chk("t4_fifth_wc", wrk_c, 97);
    chk("t4_rdy_full", 32'(arg_rdy), 0);

    // 5: spurious strobe on idle slot
    do_reset();
    wrk_res_vld = 4'b0100; wrk_res[95:64] = 32'hdead; tick();
    wrk_res_vld = '0;
    chk("t5_err", 32'(err), 1);
    chk("t5_no_res", 32'(res_vld), 0);
    tick();
    chk("t5_no_res2", 32'(res_vld), 0);
    arg_vld = 1; a = 5; b = 6; c = 7; tick();
    arg_vld = 0;
    chk("t5_wav", 32'(wrk_arg_vld), 32'h1);
    wrk_res_vld = 4'b0001; wrk_res[31:0] = 11; tick();
    wrk_res_vld = '0; tick();
    chk("t5_res_vld", 32'(res_vld), 1);
    chk("t5_res", res, 11);
    chk("t5_err_sticky", 32'(err), 1);
    // strobe on a slot already holding a result is also an error (fresh reset)
    do_reset();
    chk("t5_err_cleared", 32'(err), 0);

    // 6: N=3 wrap and order with random latencies
    for (int i = 0; i < 10; i++) begin
      int waited;
      logic ok;
      arg_vld3 = 1; a3 = 32'(i * 3 + 1); b3 = 32'(i * 5); c3 = 32'(i * 7 + 2);
      waited = 0;
      do begin
        ok = arg_rdy3;
        tick();
        waited++;
      end while (!ok && waited < 200);
      if (!ok) chk("t6_accept_timeout", 32'(waited), 0);
      exp3.push_back(a3 + b3 + c3);
    end
    arg_vld3 = 0;
    begin
      int waited = 0;
      while (got3.size() < 10 && waited < 500) begin
        tick();
        waited++;
      end
    end
    repeat (5) tick();
    chk("t6_count", 32'(got3.size()), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < got3.size()) chk($sformatf("t6_res%0d", i), got3[i], exp3[i]);
    end
    chk("t6_err", 32'(err3), 0);
    chk("t6_rdy_idle", 32'(arg_rdy3), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
